// File: rtl/bsg_dff_en_pipe_pkg.sv
// Shared helpers for the enabled, flushable, bubble-collapsing register pipe.
// Latency: none (combinational helper only).
// Backpressure: not applicable; the helper encodes the per-stage advance rule.
package bsg_dff_en_pipe_pkg;

    // A stage advances when the pipe is enabled, not flushing, and the stage
    // is either empty or its current word is leaving in the same cycle.
    function automatic logic stage_adv(
        input logic en,
        input logic flush,
        input logic vld,
        input logic moves_on
    );
        return en & ~flush & (~vld | moves_on);
    endfunction

endpackage

// File: rtl/bsg_dff_en_pipe_stage.sv
// One pipe stage: a valid bit plus a data register with load enable.
// Latency: 1 cycle from load to output.
// Backpressure: loads only when adv_i is high; flush_i clears valid unconditionally.
//
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   adv_i            : stage takes its upstream word (or bubble) this cycle
//   flush_i          : clear valid on the next edge, data holds
//   v_i, data_i      : upstream valid and data
//   v_o, data_o      : stage valid and data register
module bsg_dff_en_pipe_stage
    import bsg_dff_en_pipe_pkg::*;
#(
    parameter int width_p     = 64,
    parameter     reset_val_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               adv_i,
    input  logic               flush_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    localparam logic [width_p-1:0] RST_DATA = width_p'(reset_val_p);

    logic               v_r;
    logic [width_p-1:0] data_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_r <= 1'b0;
        end else if (flush_i) begin
            v_r <= 1'b0;
        end else if (adv_i) begin
            v_r <= v_i;
        end
    end

    // Data only changes when a real word arrives; a bubble leaves it holding.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_r <= RST_DATA;
        end else if (adv_i && v_i) begin
            data_r <= data_i;
        end
    end

    assign v_o    = v_r;
    assign data_o = data_r;

endmodule

// File: rtl/bsg_dff_en_pipe.sv
// Enabled, flushable, bubble-collapsing ready/valid register pipe of els_p stages.
// Latency: els_p cycles from accept to v_o on an empty pipe; one word/cycle sustained.
// Backpressure: ready_o follows the advance chain combinationally from yumi_i.
//
// Ports:
//   clk_i, reset_n_i       : clock, async active-low reset
//   en_i                   : global enable, 0 freezes all state and hides v_o
//   flush_i                : drop every in-flight word on the next edge
//   v_i, data_i, ready_o   : input handshake
//   v_o, data_o, yumi_i    : output handshake (yumi_i only while v_o)
//   count_o                : number of valid stages
module bsg_dff_en_pipe
    import bsg_dff_en_pipe_pkg::*;
#(
    parameter int width_p     = 64,
    parameter int els_p       = 2,
    parameter     reset_val_p = 0,
    parameter int harden_p    = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       en_i,
    input  logic                       flush_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(els_p + 1);

    logic [els_p-1:0]              stage_v;
    logic [els_p-1:0][width_p-1:0] stage_data;

    // There is no hardened variant; any harden_p value builds the same pipe.
    if (harden_p != 0) begin : g_harden_compat
    end

    genvar k;
    for (k = 0; k < els_p; k++) begin : g_stage
        logic               adv;
        logic               moves_on;
        logic               up_v;
        logic [width_p-1:0] up_data;

        // Chain runs from the output stage backward: each stage only moves
        // on when the stage in front of it advances.
        if (k == els_p - 1) begin : g_tail
            assign moves_on = yumi_i;
        end else begin : g_body
            assign moves_on = g_stage[k+1].adv;
        end

        if (k == 0) begin : g_head
            assign up_v    = v_i;
            assign up_data = data_i;
        end else begin : g_link
            assign up_v    = stage_v[k-1];
            assign up_data = stage_data[k-1];
        end

        assign adv = stage_adv(en_i, flush_i, stage_v[k], moves_on);

        bsg_dff_en_pipe_stage #(
            .width_p     (width_p),
            .reset_val_p (reset_val_p)
        ) u_stage (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .adv_i     (adv),
            .flush_i   (flush_i),
            .v_i       (up_v),
            .data_i    (up_data),
            .v_o       (stage_v[k]),
            .data_o    (stage_data[k])
        );
    end

    // Gating with reset keeps ready_o low while the pipe is held in reset,
    // even though the cleared valid bits would otherwise make stage 0 look free.
    assign ready_o = g_stage[0].adv & reset_n_i;
    assign v_o     = stage_v[els_p-1] & en_i;
    assign data_o  = stage_data[els_p-1];

    always_comb begin
        count_o = '0;
        for (int i = 0; i < els_p; i++) begin
            count_o = count_o + CNT_W'(stage_v[i]);
        end
    end

endmodule
